// File: rtl/rv_pkg.sv
// Shared RV32I front-end definitions: instruction width, canonical NOP and the fetch entry layout.
package rv_pkg;

  localparam int unsigned ILEN     = 32;
  localparam int unsigned PC_W_DEF = 8;
  localparam logic [ILEN-1:0] RV_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [PC_W_DEF-1:0] pc;
    logic [ILEN-1:0]     inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-queue bus: imem request/grant, redirect, decode handshake and status.
interface fetch_queue_if
  import rv_pkg::*;
#(
  parameter int unsigned PC_W   = 8,
  parameter int unsigned INST_W = ILEN,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic              pc_en;
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_gnt;
  logic [INST_W-1:0] imem_rdata;
  logic              redirect;
  logic [PC_W-1:0]   redirect_pc;
  logic              if_valid;
  logic [INST_W-1:0] if_inst;
  logic [PC_W-1:0]   if_pc;
  logic              id_ready;
  logic [CntW-1:0]   fq_count;
  logic              err_misalign;

  modport master (
    input  pc_en, imem_gnt, imem_rdata, redirect, redirect_pc, id_ready,
    output imem_req, imem_addr, if_valid, if_inst, if_pc, fq_count, err_misalign
  );

  modport slave (
    output pc_en, imem_gnt, imem_rdata, redirect, redirect_pc, id_ready,
    input  imem_req, imem_addr, if_valid, if_inst, if_pc, fq_count, err_misalign
  );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush, registered storage and combinational head read.
module fetch_fifo #(
  parameter int unsigned WIDTH = 40,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC register, imem request/redirect control and a fetch buffer.
module fetch_queue
  import rv_pkg::*;
#(
  parameter int unsigned     PC_W     = 8,
  parameter int unsigned     INST_W   = ILEN,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.master bus
);
  localparam int unsigned EntW = PC_W + INST_W;

  logic [PC_W-1:0] pc_q;
  logic            err_q;
  logic            fetch, pop, full, empty;
  logic [EntW-1:0] head;

  assign pop          = bus.if_valid && bus.id_ready;
  // A pop frees a slot in the same cycle, so a full queue may still request.
  assign bus.imem_req = bus.pc_en && !rst && (!full || pop);
  assign fetch        = bus.imem_req && bus.imem_gnt && !bus.redirect;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_PC;
      err_q <= 1'b0;
    end else if (bus.redirect) begin
      pc_q <= {bus.redirect_pc[PC_W-1:2], 2'b00};
      if (bus.redirect_pc[1:0] != 2'b00) err_q <= 1'b1;
    end else if (fetch) begin
      pc_q <= pc_q + PC_W'(4);
    end
  end

  fetch_fifo #(
    .WIDTH (EntW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (bus.redirect),
    .push  (fetch),
    .pop   (pop && !bus.redirect),
    .wdata ({pc_q, bus.imem_rdata}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (bus.fq_count)
  );

  assign bus.imem_addr    = pc_q;
  assign bus.if_valid     = !empty;
  assign bus.if_pc        = bus.if_valid ? head[EntW-1:INST_W] : '0;
  assign bus.if_inst      = bus.if_valid ? head[INST_W-1:0] : '0;
  assign bus.err_misalign = err_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: streaming, backpressure, redirects, wrap and reset.
module tb_fetch_queue;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fetch_queue_if #(.PC_W(8), .INST_W(32), .DEPTH(4)) bus ();

  fetch_queue #(.PC_W(8), .INST_W(32), .DEPTH(4), .RESET_PC(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // Memory returns a word tagged with its own address.
  assign bus.imem_rdata = 32'hC0DE_0000 | {24'h0, bus.imem_addr};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.pc_en = 1'b0; bus.imem_gnt = 1'b0; bus.id_ready = 1'b0;
    bus.redirect = 1'b0; bus.redirect_pc = 8'h00;
    step(); step();
    bus.pc_en = 1'b1; #1;
    checks++; if (bus.imem_req !== 1'b0) begin failures++;
      $display("FAIL reset_req got=%0b exp=0", bus.imem_req); end
    checks++; if (bus.imem_addr !== 8'h00) begin failures++;
      $display("FAIL reset_addr got=%0h exp=0", bus.imem_addr); end
    checks++; if (bus.if_valid !== 1'b0 || bus.if_pc !== 8'h00 || bus.if_inst !== 32'h0) begin
      failures++; $display("FAIL reset_head got v=%0b pc=%0h inst=%0h exp 0/0/0",
                           bus.if_valid, bus.if_pc, bus.if_inst); end
    checks++; if (bus.fq_count !== 3'd0 || bus.err_misalign !== 1'b0) begin failures++;
      $display("FAIL reset_status got cnt=%0d err=%0b exp 0/0", bus.fq_count, bus.err_misalign); end
  endtask

  task automatic test_stream();
    rst = 1'b0; bus.imem_gnt = 1'b1; bus.id_ready = 1'b1; #1;
    checks++; if (bus.imem_req !== 1'b1) begin failures++;
      $display("FAIL stream_req got=%0b exp=1", bus.imem_req); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.imem_addr !== 8'(4 * i)) begin failures++;
        $display("FAIL stream_addr[%0d] got=%0h exp=%0h", i, bus.imem_addr, 4 * i); end
      if (i > 0) begin
        checks++;
        if (bus.if_pc !== 8'(4 * (i - 1)) || bus.if_inst !== (32'hC0DE_0000 | 32'(4 * (i - 1)))
            || bus.fq_count !== 3'd1) begin
          failures++; $display("FAIL stream_head[%0d] got pc=%0h inst=%0h cnt=%0d exp pc=%0h cnt=1",
                               i, bus.if_pc, bus.if_inst, bus.fq_count, 4 * (i - 1)); end
      end
      step();
    end
  endtask

  task automatic test_fill();
    int pushes = 0;
    bus.pc_en = 1'b0; #1;
    checks++; if (bus.imem_req !== 1'b0) begin failures++;
      $display("FAIL drain_req got=%0b exp=0", bus.imem_req); end
    step();
    checks++; if (bus.if_valid !== 1'b0 || bus.if_pc !== 8'h00 || bus.if_inst !== 32'h0
                  || bus.imem_addr !== 8'h14) begin failures++;
      $display("FAIL drain_state got v=%0b pc=%0h inst=%0h addr=%0h exp 0/0/0/14",
               bus.if_valid, bus.if_pc, bus.if_inst, bus.imem_addr); end
    bus.pc_en = 1'b1; bus.id_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1; if (bus.imem_req) pushes++;
      step();
    end
    checks++; if (pushes != 4) begin failures++;
      $display("FAIL fill_pushes got=%0d exp=4", pushes); end
    checks++; if (bus.fq_count !== 3'd4 || bus.imem_req !== 1'b0 || bus.imem_addr !== 8'h24) begin
      failures++; $display("FAIL fill_full got cnt=%0d req=%0b addr=%0h exp 4/0/24",
                           bus.fq_count, bus.imem_req, bus.imem_addr); end
    checks++; if (bus.if_pc !== 8'h14 || bus.if_inst !== 32'hC0DE_0014) begin failures++;
      $display("FAIL fill_head got pc=%0h inst=%0h exp 14/c0de0014", bus.if_pc, bus.if_inst); end
    bus.id_ready = 1'b1; #1;
    checks++; if (bus.imem_req !== 1'b1) begin failures++;
      $display("FAIL fill_resume_req got=%0b exp=1", bus.imem_req); end
    step();
    checks++; if (bus.fq_count !== 3'd4 || bus.if_pc !== 8'h18 || bus.imem_addr !== 8'h28) begin
      failures++; $display("FAIL fill_pp1 got cnt=%0d pc=%0h addr=%0h exp 4/18/28",
                           bus.fq_count, bus.if_pc, bus.imem_addr); end
    step();
    checks++; if (bus.fq_count !== 3'd4 || bus.if_pc !== 8'h1C || bus.imem_addr !== 8'h2C) begin
      failures++; $display("FAIL fill_pp2 got cnt=%0d pc=%0h addr=%0h exp 4/1c/2c",
                           bus.fq_count, bus.if_pc, bus.imem_addr); end
  endtask

  task automatic test_redirect();
    bus.pc_en = 1'b0; step();
    checks++; if (bus.fq_count !== 3'd3) begin failures++;
      $display("FAIL redir_pre_cnt got=%0d exp=3", bus.fq_count); end
    bus.redirect = 1'b1; bus.redirect_pc = 8'h40; step();
    checks++; if (bus.fq_count !== 3'd0 || bus.if_valid !== 1'b0 || bus.imem_addr !== 8'h40
                  || bus.err_misalign !== 1'b0) begin failures++;
      $display("FAIL redir_flush got cnt=%0d v=%0b addr=%0h err=%0b exp 0/0/40/0",
               bus.fq_count, bus.if_valid, bus.imem_addr, bus.err_misalign); end
    bus.redirect = 1'b0; bus.pc_en = 1'b1; #1;
    checks++; if (bus.imem_req !== 1'b1) begin failures++;
      $display("FAIL redir_req got=%0b exp=1", bus.imem_req); end
    step();
    checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 8'h40 || bus.if_inst !== 32'hC0DE_0040
                  || bus.imem_addr !== 8'h44) begin failures++;
      $display("FAIL redir_first got v=%0b pc=%0h inst=%0h addr=%0h exp 1/40/c0de0040/44",
               bus.if_valid, bus.if_pc, bus.if_inst, bus.imem_addr); end
  endtask

  task automatic test_misalign();
    bus.redirect = 1'b1; bus.redirect_pc = 8'h42; step();
    checks++; if (bus.imem_addr !== 8'h40 || bus.err_misalign !== 1'b1 || bus.fq_count !== 3'd0)
    begin failures++; $display("FAIL misalign got addr=%0h err=%0b cnt=%0d exp 40/1/0",
                                bus.imem_addr, bus.err_misalign, bus.fq_count); end
    bus.redirect = 1'b0; step(); step(); step();
    checks++; if (bus.err_misalign !== 1'b1 || bus.if_pc !== 8'h48 || bus.imem_addr !== 8'h4C)
    begin failures++; $display("FAIL misalign_sticky got err=%0b pc=%0h addr=%0h exp 1/48/4c",
                                bus.err_misalign, bus.if_pc, bus.imem_addr); end
  endtask

  task automatic test_wrap_gnt();
    logic       gnt_v   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0] addr_v  [4] = '{8'hF8, 8'hFC, 8'hFC, 8'h00};
    logic [7:0] pc_v    [4] = '{8'hF8, 8'h00, 8'hFC, 8'h00};
    logic       valid_v [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    bus.redirect = 1'b1; bus.redirect_pc = 8'hF8; step();
    bus.redirect = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.imem_gnt = gnt_v[i]; #1;
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== addr_v[i]) begin failures++;
        $display("FAIL wrap_addr[%0d] got req=%0b addr=%0h exp 1/%0h",
                 i, bus.imem_req, bus.imem_addr, addr_v[i]); end
      step();
      checks++; if (bus.if_valid !== valid_v[i] || bus.if_pc !== pc_v[i]
                    || bus.fq_count !== 3'(valid_v[i])) begin failures++;
        $display("FAIL wrap_head[%0d] got v=%0b pc=%0h cnt=%0d exp %0b/%0h/%0d",
                 i, bus.if_valid, bus.if_pc, bus.fq_count, valid_v[i], pc_v[i], valid_v[i]); end
    end
    checks++; if (bus.if_inst !== 32'hC0DE_0000 || bus.imem_addr !== 8'h04) begin failures++;
      $display("FAIL wrap_tail got inst=%0h addr=%0h exp c0de0000/04", bus.if_inst, bus.imem_addr); end
  endtask

  task automatic test_redirect_pop_full();
    bus.id_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    checks++; if (bus.fq_count !== 3'd4) begin failures++;
      $display("FAIL rpf_full got=%0d exp=4", bus.fq_count); end
    bus.id_ready = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 8'h80; step();
    checks++; if (bus.fq_count !== 3'd0 || bus.if_valid !== 1'b0 || bus.imem_addr !== 8'h80) begin
      failures++; $display("FAIL rpf_flush got cnt=%0d v=%0b addr=%0h exp 0/0/80",
                           bus.fq_count, bus.if_valid, bus.imem_addr); end
    bus.redirect = 1'b0;
  endtask

  task automatic test_rst_full();
    bus.id_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    checks++; if (bus.fq_count !== 3'd4 || bus.if_pc !== 8'h80 || bus.err_misalign !== 1'b1) begin
      failures++; $display("FAIL rstf_pre got cnt=%0d pc=%0h err=%0b exp 4/80/1",
                           bus.fq_count, bus.if_pc, bus.err_misalign); end
    rst = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 8'h20; step();
    checks++; if (bus.fq_count !== 3'd0 || bus.if_valid !== 1'b0 || bus.if_pc !== 8'h00
                  || bus.if_inst !== 32'h0) begin failures++;
      $display("FAIL rstf_queue got cnt=%0d v=%0b pc=%0h inst=%0h exp 0/0/0/0",
               bus.fq_count, bus.if_valid, bus.if_pc, bus.if_inst); end
    checks++; if (bus.imem_addr !== 8'h00 || bus.err_misalign !== 1'b0 || bus.imem_req !== 1'b0)
    begin failures++; $display("FAIL rstf_ctrl got addr=%0h err=%0b req=%0b exp 0/0/0",
                                bus.imem_addr, bus.err_misalign, bus.imem_req); end
    rst = 1'b0; bus.redirect = 1'b0; #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00) begin failures++;
      $display("FAIL rstf_release got req=%0b addr=%0h exp 1/0", bus.imem_req, bus.imem_addr); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_fill();
    test_redirect();
    test_misalign();
    test_wrap_gnt();
    test_redirect_pop_full();
    test_rst_full();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
